// File: rtl/stove_burner_ctrl.sv
// -----------------------------------------------------------------------------
// stove_burner_ctrl
//   Sequencer for a single stove burner. It owns the burner state machine and
//   steers two external register instances (heat level and countdown timer)
//   through their ctrl inputs. All numeric state lives in those registers; this
//   block only reads their outputs back as level_value / time_value.
//
// Optional feature macro: STOVE_ALARM_TIMEOUT_EN
//   defined   : the alarm in DONE clears itself after ALARM_SECS ticks.
//   undefined : DONE and alarm persist until a button pulse.
//
// Ports
//   clk          in   1               system clock, posedge
//   sync_reset   in   1               synchronous reset, active-high
//   btn_sel      in   1               select/confirm/cancel pulse
//   btn_inc      in   1               increment pulse
//   btn_dec      in   1               decrement pulse
//   tick_1hz     in   1               one-cycle pulse once per second
//   level_value  in   LEVEL_WIDTH     level register readback
//   time_value   in   TIME_WIDTH      timer register readback
//   level_ctrl   out  REG_CTRL_WIDTH  level register ctrl (combinational)
//   time_ctrl    out  REG_CTRL_WIDTH  timer register ctrl (combinational)
//   heating      out  1               burner on (registered)
//   alarm        out  1               timer expired (registered)
//   state_o      out  3               current state encoding
//
// Register ctrl codes come from register.vh when it has been read first;
// otherwise the fallback encoding below is used.
// -----------------------------------------------------------------------------
`ifndef REG_CTRL_WIDTH
`define REG_CTRL_WIDTH 3
`endif
`ifndef REG_CTRL_NOP
`define REG_CTRL_NOP 3'd0
`endif
`ifndef REG_CTRL_LD
`define REG_CTRL_LD  3'd1
`endif
`ifndef REG_CTRL_CLR
`define REG_CTRL_CLR 3'd2
`endif
`ifndef REG_CTRL_INC
`define REG_CTRL_INC 3'd3
`endif
`ifndef REG_CTRL_DEC
`define REG_CTRL_DEC 3'd4
`endif

module stove_burner_ctrl #(
    parameter int LEVEL_WIDTH = 4,
    parameter int MAX_LEVEL   = 9,
    parameter int TIME_WIDTH  = 8,
    parameter int MAX_TIME    = 99,
    parameter int ALARM_SECS  = 10
) (
    input  logic                       clk,
    input  logic                       sync_reset,
    input  logic                       btn_sel,
    input  logic                       btn_inc,
    input  logic                       btn_dec,
    input  logic                       tick_1hz,
    input  logic [LEVEL_WIDTH-1:0]     level_value,
    input  logic [TIME_WIDTH-1:0]      time_value,
    output logic [`REG_CTRL_WIDTH-1:0] level_ctrl,
    output logic [`REG_CTRL_WIDTH-1:0] time_ctrl,
    output logic                       heating,
    output logic                       alarm,
    output logic [2:0]                 state_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SET_LEVEL = 3'd1,
        ST_SET_TIME  = 3'd2,
        ST_RUNNING   = 3'd3,
        ST_DONE      = 3'd4
    } state_t;

    state_t state_q, state_d;
    logic   heating_q;
    logic   alarm_q;
    logic   timed_q, timed_d;

`ifdef STOVE_ALARM_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(ALARM_SECS + 1);
    logic [CNT_WIDTH-1:0] alarm_cnt_q, alarm_cnt_d;
`else
    // Timeout length only matters when the self-clearing alarm is built in.
    logic unused_alarm_secs_s;
    assign unused_alarm_secs_s = (ALARM_SECS > 0);
`endif

    // Readback qualifiers; out-of-range values count as saturated at max.
    logic level_at_max_s, level_zero_s, level_one_s;
    logic time_at_max_s, time_zero_s, time_one_s;
    logic inc_only_s, dec_only_s, any_btn_s;

    assign level_at_max_s = (level_value >= LEVEL_WIDTH'(MAX_LEVEL));
    assign level_zero_s   = (level_value == {LEVEL_WIDTH{1'b0}});
    assign level_one_s    = (level_value == LEVEL_WIDTH'(1));
    assign time_at_max_s  = (time_value  >= TIME_WIDTH'(MAX_TIME));
    assign time_zero_s    = (time_value  == {TIME_WIDTH{1'b0}});
    assign time_one_s     = (time_value  == TIME_WIDTH'(1));

    // Pressing inc and dec together cancels out to no adjustment.
    assign inc_only_s = btn_inc & ~btn_dec;
    assign dec_only_s = btn_dec & ~btn_inc;
    assign any_btn_s  = btn_sel | btn_inc | btn_dec;

    // Next-state and register ctrl decode; sel beats inc/dec beats tick.
    always_comb begin
        state_d    = state_q;
        timed_d    = timed_q;
        level_ctrl = `REG_CTRL_NOP;
        time_ctrl  = `REG_CTRL_NOP;
`ifdef STOVE_ALARM_TIMEOUT_EN
        alarm_cnt_d = alarm_cnt_q;
`endif
        if (sync_reset) begin
            level_ctrl = `REG_CTRL_CLR;
            time_ctrl  = `REG_CTRL_CLR;
            state_d    = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (btn_sel) begin
                        state_d = ST_SET_LEVEL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SET_LEVEL: begin
                    if (btn_sel) begin
                        // Confirming a zero level means the user backed out.
                        if (level_zero_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_SET_TIME;
                        end
                    end else if (inc_only_s && !level_at_max_s) begin
                        level_ctrl = `REG_CTRL_INC;
                    end else if (dec_only_s && !level_zero_s) begin
                        level_ctrl = `REG_CTRL_DEC;
                    end else begin
                        level_ctrl = `REG_CTRL_NOP;
                    end
                end
                ST_SET_TIME: begin
                    if (btn_sel) begin
                        state_d = ST_RUNNING;
                        // A zero timer at start means run until cancelled.
                        timed_d = !time_zero_s;
                    end else if (inc_only_s && !time_at_max_s) begin
                        time_ctrl = `REG_CTRL_INC;
                    end else if (dec_only_s && !time_zero_s) begin
                        time_ctrl = `REG_CTRL_DEC;
                    end else begin
                        time_ctrl = `REG_CTRL_NOP;
                    end
                end
                ST_RUNNING: begin
                    if (btn_sel) begin
                        // Cancel wins even over the final tick: no alarm.
                        level_ctrl = `REG_CTRL_CLR;
                        time_ctrl  = `REG_CTRL_CLR;
                        state_d    = ST_IDLE;
                    end else if (inc_only_s) begin
                        if (!level_at_max_s) begin
                            level_ctrl = `REG_CTRL_INC;
                        end else begin
                            level_ctrl = `REG_CTRL_NOP;
                        end
                    end else if (dec_only_s) begin
                        if (level_one_s) begin
                            // Turning the flame down to zero switches the burner off.
                            level_ctrl = `REG_CTRL_DEC;
                            time_ctrl  = `REG_CTRL_CLR;
                            state_d    = ST_IDLE;
                        end else if (!level_zero_s) begin
                            level_ctrl = `REG_CTRL_DEC;
                        end else begin
                            level_ctrl = `REG_CTRL_NOP;
                        end
                    end else if (btn_inc || btn_dec) begin
                        // inc+dec together still consumes the cycle ahead of tick.
                        level_ctrl = `REG_CTRL_NOP;
                    end else if (tick_1hz && timed_q) begin
                        if (time_one_s) begin
                            time_ctrl  = `REG_CTRL_DEC;
                            level_ctrl = `REG_CTRL_CLR;
                            state_d    = ST_DONE;
                        end else if (!time_zero_s) begin
                            time_ctrl = `REG_CTRL_DEC;
                        end else begin
                            time_ctrl = `REG_CTRL_NOP;
                        end
                    end else begin
                        state_d = ST_RUNNING;
                    end
                end
                ST_DONE: begin
                    if (any_btn_s) begin
                        state_d = ST_IDLE;
                    end
`ifdef STOVE_ALARM_TIMEOUT_EN
                    else if (tick_1hz) begin
                        if (alarm_cnt_q == CNT_WIDTH'(ALARM_SECS - 1)) begin
                            state_d = ST_IDLE;
                        end else begin
                            alarm_cnt_d = alarm_cnt_q + CNT_WIDTH'(1);
                        end
                    end
`endif
                    else begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
`ifdef STOVE_ALARM_TIMEOUT_EN
            // Restart the alarm timeout on every entry into DONE.
            if (state_d == ST_DONE && state_q != ST_DONE) begin
                alarm_cnt_d = {CNT_WIDTH{1'b0}};
            end else begin
                alarm_cnt_d = alarm_cnt_d;
            end
`endif
        end
    end

    // State and Moore output registers; outputs track the next state.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q   <= ST_IDLE;
            heating_q <= 1'b0;
            alarm_q   <= 1'b0;
            timed_q   <= 1'b0;
`ifdef STOVE_ALARM_TIMEOUT_EN
            alarm_cnt_q <= {CNT_WIDTH{1'b0}};
`endif
        end else begin
            state_q   <= state_d;
            heating_q <= (state_d == ST_RUNNING);
            alarm_q   <= (state_d == ST_DONE);
            timed_q   <= timed_d;
`ifdef STOVE_ALARM_TIMEOUT_EN
            alarm_cnt_q <= alarm_cnt_d;
`endif
        end
    end

    assign heating = heating_q;
    assign alarm   = alarm_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_stove_burner_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stove_burner_ctrl
//   Directed bench for stove_burner_ctrl. A behavioural model of the two
//   external registers closes the ctrl/value loop. Each stimulus cycle pushes
//   its hand-computed expectation into a queue; a forked monitor pops and
//   compares on the falling edge of that cycle.
// -----------------------------------------------------------------------------
module tb_stove_burner_ctrl;

    localparam logic [2:0] N = 3'd0;  // NOP
    localparam logic [2:0] C = 3'd2;  // CLR
    localparam logic [2:0] I = 3'd3;  // INC
    localparam logic [2:0] D = 3'd4;  // DEC

    logic       clk = 1'b0;
    logic       sync_reset;
    logic       btn_sel, btn_inc, btn_dec, tick_1hz;
    logic [3:0] level_value;
    logic [7:0] time_value;
    logic [2:0] level_ctrl, time_ctrl, state_o;
    logic       heating, alarm;

    logic       pre_en;
    logic [3:0] pre_lv;
    logic [7:0] pre_tm;

    typedef struct {
        logic [2:0] lc;
        logic [2:0] tc;
        logic [2:0] st;
        logic       ht;
        logic       al;
        logic [3:0] lv;
        logic [7:0] tm;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_fail;

    stove_burner_ctrl dut (
        .clk         (clk),
        .sync_reset  (sync_reset),
        .btn_sel     (btn_sel),
        .btn_inc     (btn_inc),
        .btn_dec     (btn_dec),
        .tick_1hz    (tick_1hz),
        .level_value (level_value),
        .time_value  (time_value),
        .level_ctrl  (level_ctrl),
        .time_ctrl   (time_ctrl),
        .heating     (heating),
        .alarm       (alarm),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    // Level and timer register models; preload lets the bench seed values.
    always @(posedge clk) begin
        if (pre_en) begin
            level_value <= pre_lv;
            time_value  <= pre_tm;
        end else begin
            case (level_ctrl)
                C:       level_value <= 4'd0;
                I:       level_value <= level_value + 4'd1;
                D:       level_value <= level_value - 4'd1;
                default: level_value <= level_value;
            endcase
            case (time_ctrl)
                C:       time_value <= 8'd0;
                I:       time_value <= time_value + 8'd1;
                D:       time_value <= time_value - 8'd1;
                default: time_value <= time_value;
            endcase
        end
    end

    // One cycle: drive inputs, queue what this cycle must show, advance.
    task automatic step(input logic s, input logic inc, input logic dec, input logic tk,
                        input logic [2:0] elc, input logic [2:0] etc_v, input logic [2:0] est,
                        input logic eht, input logic eal, input logic [3:0] elv,
                        input logic [7:0] etm, input string nm);
        exp_t e;
        btn_sel  = s;
        btn_inc  = inc;
        btn_dec  = dec;
        tick_1hz = tk;
        e.lc = elc; e.tc = etc_v; e.st = est; e.ht = eht; e.al = eal;
        e.lv = elv; e.tm = etm; e.name = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        sync_reset = 1'b1;
        btn_sel = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; tick_1hz = 1'b0;
        pre_en = 1'b1; pre_lv = 4'd5; pre_tm = 8'd30;

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_cmp++;
                    if ({level_ctrl, time_ctrl, state_o, heating, alarm, level_value, time_value} !==
                        {e.lc, e.tc, e.st, e.ht, e.al, e.lv, e.tm}) begin
                        n_fail++;
                        $display("FAIL %s: got lc=%0d tc=%0d st=%0d heat=%0b alarm=%0b lv=%0d tm=%0d, required lc=%0d tc=%0d st=%0d heat=%0b alarm=%0b lv=%0d tm=%0d",
                                 e.name, level_ctrl, time_ctrl, state_o, heating, alarm,
                                 level_value, time_value, e.lc, e.tc, e.st, e.ht, e.al, e.lv, e.tm);
                    end
                end
            end
        join_none

        // Test 1: reset with registers seeded at level 5, time 30.
        @(posedge clk);
        #1;
        pre_en = 1'b0;
        step(0, 0, 0, 0, C, C, 3'd0, 0, 0, 4'd5, 8'd30, "rst_hold");
        step(0, 0, 0, 0, C, C, 3'd0, 0, 0, 4'd0, 8'd0, "rst_clr");
        sync_reset = 1'b0;

        // Test 2: set level 3, time 2, run to DONE, acknowledge.
        step(0, 0, 0, 0, N, N, 3'd0, 0, 0, 4'd0, 8'd0, "t2_idle");
        step(1, 0, 0, 0, N, N, 3'd0, 0, 0, 4'd0, 8'd0, "t2_sel");
        step(0, 1, 0, 0, I, N, 3'd1, 0, 0, 4'd0, 8'd0, "t2_lv_inc1");
        step(0, 1, 0, 0, I, N, 3'd1, 0, 0, 4'd1, 8'd0, "t2_lv_inc2");
        step(0, 1, 0, 0, I, N, 3'd1, 0, 0, 4'd2, 8'd0, "t2_lv_inc3");
        step(1, 0, 0, 0, N, N, 3'd1, 0, 0, 4'd3, 8'd0, "t2_lv_sel");
        step(0, 1, 0, 0, N, I, 3'd2, 0, 0, 4'd3, 8'd0, "t2_tm_inc1");
        step(0, 1, 0, 0, N, I, 3'd2, 0, 0, 4'd3, 8'd1, "t2_tm_inc2");
        step(1, 0, 0, 0, N, N, 3'd2, 0, 0, 4'd3, 8'd2, "t2_tm_sel");
        step(0, 0, 0, 0, N, N, 3'd3, 1, 0, 4'd3, 8'd2, "t2_running");
        step(0, 0, 0, 1, N, D, 3'd3, 1, 0, 4'd3, 8'd2, "t2_tick1");
        step(0, 0, 0, 1, C, D, 3'd3, 1, 0, 4'd3, 8'd1, "t2_tick_last");
        step(0, 0, 0, 0, N, N, 3'd4, 0, 1, 4'd0, 8'd0, "t2_done");
        step(0, 1, 0, 0, N, N, 3'd4, 0, 1, 4'd0, 8'd0, "t2_ack");
        step(0, 0, 0, 0, N, N, 3'd0, 0, 0, 4'd0, 8'd0, "t2_idle_after");

        // Test 3: level saturation both ways, timer floor and ceiling.
        step(1, 0, 0, 0, N, N, 3'd0, 0, 0, 4'd0, 8'd0, "t3_sel");
        for (int i = 0; i < 12; i++)
            step(0, 1, 0, 0, (i < 9) ? I : N, N, 3'd1, 0, 0,
                 (i < 9) ? 4'(i) : 4'd9, 8'd0, "t3_lv_inc_sat");
        for (int i = 0; i < 12; i++)
            step(0, 0, 1, 0, (i < 9) ? D : N, N, 3'd1, 0, 0,
                 (i < 9) ? 4'(9 - i) : 4'd0, 8'd0, "t3_lv_dec_sat");
        step(0, 1, 0, 0, I, N, 3'd1, 0, 0, 4'd0, 8'd0, "t3_lv_up");
        step(1, 0, 0, 0, N, N, 3'd1, 0, 0, 4'd1, 8'd0, "t3_lv_sel");
        step(0, 0, 1, 0, N, N, 3'd2, 0, 0, 4'd1, 8'd0, "t3_tm_dec_at0");
        pre_en = 1'b1; pre_lv = 4'd1; pre_tm = 8'd99;
        step(0, 0, 0, 0, N, N, 3'd2, 0, 0, 4'd1, 8'd0, "t3_tm_stays0");
        pre_en = 1'b0;
        step(0, 1, 0, 0, N, N, 3'd2, 0, 0, 4'd1, 8'd99, "t3_tm_inc_at_max");
        step(0, 0, 1, 0, N, D, 3'd2, 0, 0, 4'd1, 8'd99, "t3_tm_dec_from_max");
        pre_en = 1'b1; pre_lv = 4'd1; pre_tm = 8'd1;
        step(0, 0, 0, 0, N, N, 3'd2, 0, 0, 4'd1, 8'd98, "t3_tm_98");
        pre_en = 1'b0;

        // Test 4: cancel racing the last tick, then inc+dec together.
        step(1, 0, 0, 0, N, N, 3'd2, 0, 0, 4'd1, 8'd1, "t4_start");
        step(1, 0, 0, 1, C, C, 3'd3, 1, 0, 4'd1, 8'd1, "t4_race");
        step(0, 0, 0, 0, N, N, 3'd0, 0, 0, 4'd0, 8'd0, "t4_no_alarm");
        step(1, 0, 0, 0, N, N, 3'd0, 0, 0, 4'd0, 8'd0, "t4_sel");
        step(0, 1, 0, 0, I, N, 3'd1, 0, 0, 4'd0, 8'd0, "t4_inc");
        step(0, 1, 1, 0, N, N, 3'd1, 0, 0, 4'd1, 8'd0, "t4_incdec");
        step(0, 0, 0, 0, N, N, 3'd1, 0, 0, 4'd1, 8'd0, "t4_lv_same");

        // Test 5: untimed run ignores ticks; dec at level 1 turns off.
        step(1, 0, 0, 0, N, N, 3'd1, 0, 0, 4'd1, 8'd0, "t5_lv_sel");
        step(1, 0, 0, 0, N, N, 3'd2, 0, 0, 4'd1, 8'd0, "t5_tm_sel");
        for (int i = 0; i < 5; i++)
            step(0, 0, 0, 1, N, N, 3'd3, 1, 0, 4'd1, 8'd0, "t5_untimed_tick");
        step(0, 0, 1, 0, D, C, 3'd3, 1, 0, 4'd1, 8'd0, "t5_dec_off");
        step(0, 0, 0, 0, N, N, 3'd0, 0, 0, 4'd0, 8'd0, "t5_off");

        // Test 6: alarm timeout (macro on) or persistence (macro off).
        step(1, 0, 0, 0, N, N, 3'd0, 0, 0, 4'd0, 8'd0, "t6_sel");
        step(0, 1, 0, 0, I, N, 3'd1, 0, 0, 4'd0, 8'd0, "t6_lv_inc");
        step(1, 0, 0, 0, N, N, 3'd1, 0, 0, 4'd1, 8'd0, "t6_lv_sel");
        step(0, 1, 0, 0, N, I, 3'd2, 0, 0, 4'd1, 8'd0, "t6_tm_inc");
        step(1, 0, 0, 0, N, N, 3'd2, 0, 0, 4'd1, 8'd1, "t6_tm_sel");
        step(0, 0, 0, 1, C, D, 3'd3, 1, 0, 4'd1, 8'd1, "t6_expire");
`ifdef STOVE_ALARM_TIMEOUT_EN
        for (int i = 0; i < 10; i++)
            step(0, 0, 0, 1, N, N, 3'd4, 0, 1, 4'd0, 8'd0, "t6_done_tick");
        step(0, 0, 0, 0, N, N, 3'd0, 0, 0, 4'd0, 8'd0, "t6_timeout_idle");
`else
        for (int i = 0; i < 20; i++)
            step(0, 0, 0, 1, N, N, 3'd4, 0, 1, 4'd0, 8'd0, "t6_done_tick");
        step(0, 0, 0, 0, N, N, 3'd4, 0, 1, 4'd0, 8'd0, "t6_persist");
        step(1, 0, 0, 0, N, N, 3'd4, 0, 1, 4'd0, 8'd0, "t6_ack");
        step(0, 0, 0, 0, N, N, 3'd0, 0, 0, 4'd0, 8'd0, "t6_idle");
`endif
        btn_sel = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; tick_1hz = 1'b0;

        // Bounded drain of the scoreboard.
        repeat (4) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
